// File: rtl/fb_arbiter_if.sv
// Framebuffer arbiter bus: display read port, pixel writer handshake, clear
// control and the single-ported memory side, bundled for one connection.
interface fb_arbiter_if #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 16
);
  logic              vga_rd;
  logic [ADDR_W-1:0] vga_addr;
  logic [DATA_W-1:0] vga_data;

  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  logic              clr_start;
  logic [DATA_W-1:0] clr_color;
  logic              clr_busy;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Arbiter side.
  modport slave (
    input  vga_rd, vga_addr, wr_valid, wr_addr, wr_data,
           clr_start, clr_color, mem_rdata,
    output vga_data, wr_ready, clr_busy, mem_addr, mem_we, mem_wdata
  );

  // Display, writer and memory side.
  modport master (
    output vga_rd, vga_addr, wr_valid, wr_addr, wr_data,
           clr_start, clr_color, mem_rdata,
    input  vga_data, wr_ready, clr_busy, mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/fb_arbiter.sv
// Single-port framebuffer arbiter: display reads always win, buffered pixel
// writes and a full-screen clear fill the memory on the remaining cycles.
module fb_arbiter #(
  parameter int ADDR_W     = 19,
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int FB_SIZE    = 307200
) (
  input  logic        clk,
  input  logic        rstn,
  fb_arbiter_if.slave bus
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_SIZE - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FLUSH,
    ST_CLEAR
  } state_e;

  state_e            state_q, state_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic [DATA_W-1:0] color_q, color_d;
  logic              clr_busy_q, clr_busy_d;

  logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];

  logic fifo_empty;
  logic fifo_full;
  logic push;
  logic pop;
  logic clr_wr;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FULL_CNT);

  // The FIFO can only hold entries outside CLEAR, since CLEAR is entered
  // empty and pushes are refused once a clear has been accepted.
  assign push   = bus.wr_valid && bus.wr_ready;
  assign pop    = !bus.vga_rd && !fifo_empty && (state_q != ST_CLEAR);
  assign clr_wr = !bus.vga_rd && (state_q == ST_CLEAR);

  assign bus.wr_ready = !fifo_full && (state_q == ST_IDLE);
  assign bus.vga_data = bus.mem_rdata;
  assign bus.clr_busy = clr_busy_q;

  // Memory port mux: stays combinational so display latency is untouched.
  always_comb begin
    // NOTE: every signal assigned in always_comb gets a default up front;
    // a path that leaves one unassigned would infer a latch.
    bus.mem_we    = 1'b0;
    bus.mem_addr  = bus.vga_addr;
    bus.mem_wdata = '0;
    if (pop) begin
      bus.mem_we    = 1'b1;
      bus.mem_addr  = fifo_addr_q[rd_ptr_q];
      bus.mem_wdata = fifo_data_q[rd_ptr_q];
    end else if (clr_wr) begin
      bus.mem_we    = 1'b1;
      bus.mem_addr  = clr_cnt_q;
      bus.mem_wdata = color_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    color_d   = color_q;
    wr_ptr_d  = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d  = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d   = count_q;

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    unique case (state_q)
      ST_IDLE: begin
        if (bus.clr_start) begin
          color_d = bus.clr_color;
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        // Checked before this cycle's pop, so the cycle that finds the
        // FIFO empty is the one extra FLUSH cycle before the sweep.
        if (fifo_empty) begin
          state_d   = ST_CLEAR;
          clr_cnt_d = '0;
        end
      end
      ST_CLEAR: begin
        if (clr_wr) begin
          if (clr_cnt_q == LAST_ADDR) begin
            state_d   = ST_IDLE;
            clr_cnt_d = '0;
          end else begin
            clr_cnt_d = clr_cnt_q + ADDR_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    clr_busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      clr_cnt_q  <= '0;
      color_q    <= '0;
      clr_busy_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      clr_cnt_q  <= clr_cnt_d;
      color_q    <= color_d;
      clr_busy_q <= clr_busy_d;
    end
  end

  // NOTE: the storage array is deliberately left out of reset; entries are
  // only ever read after being written, and the empty count guards them.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= bus.wr_addr;
      fifo_data_q[wr_ptr_q] <= bus.wr_data;
    end
  end

endmodule

// File: tb/tb_fb_arbiter.sv
// Self-checking bench for fb_arbiter: directed scenarios plus random traffic,
// all compared cycle by cycle against a queue-based model of the arbiter.
module tb_fb_arbiter;

  localparam int AW    = 19;
  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam int FBS   = 16;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  fb_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  fb_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH), .FB_SIZE(FBS)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  // Model: pending pixels in arrival order, plus the outstanding clear.
  wr_t           pix_q[$];
  wr_t           log_q[$];
  bit            busy_m;
  bit            flushed_m;
  int            idx_m;
  logic [DW-1:0] color_m;

  int total = 0;
  int bad   = 0;

  task automatic model_reset();
    pix_q.delete();
    busy_m    = 1'b0;
    flushed_m = 1'b0;
    idx_m     = 0;
    color_m   = '0;
  endtask

  // One clock: compare outputs at the falling edge, update model after rise.
  task automatic step();
    bit            rd, wv, cs, was_busy, exp_ready, pix_wr, clr_wr, exp_we;
    logic [AW-1:0] exp_addr, wa;
    logic [DW-1:0] exp_data, wd, cc, rdat;
    int            npix;
    bus.mem_rdata = DW'($urandom);
    @(negedge clk);
    rd = bus.vga_rd; wv = bus.wr_valid; cs = bus.clr_start;
    wa = bus.wr_addr; wd = bus.wr_data; cc = bus.clr_color;
    rdat = bus.mem_rdata;
    was_busy  = busy_m;
    npix      = pix_q.size();
    exp_ready = !busy_m && (npix < DEPTH);
    pix_wr    = !rd && (npix > 0);
    clr_wr    = !rd && !pix_wr && busy_m && flushed_m;
    exp_we    = pix_wr || clr_wr;
    exp_addr  = pix_wr ? pix_q[0].addr : (clr_wr ? AW'(idx_m) : bus.vga_addr);
    exp_data  = pix_wr ? pix_q[0].data : color_m;

    total++;
    if (bus.vga_data !== rdat) begin
      bad++;
      if (bad < 40) $display("FAIL vga_data t=%0t got=%h exp=%h", $time, bus.vga_data, rdat);
    end
    total++;
    if (bus.wr_ready !== exp_ready) begin
      bad++;
      if (bad < 40) $display("FAIL wr_ready t=%0t got=%b exp=%b", $time, bus.wr_ready, exp_ready);
    end
    total++;
    if (bus.clr_busy !== busy_m) begin
      bad++;
      if (bad < 40) $display("FAIL clr_busy t=%0t got=%b exp=%b", $time, bus.clr_busy, busy_m);
    end
    total++;
    if (bus.mem_we !== exp_we) begin
      bad++;
      if (bad < 40) $display("FAIL mem_we t=%0t got=%b exp=%b", $time, bus.mem_we, exp_we);
    end
    total++;
    if (bus.mem_addr !== exp_addr) begin
      bad++;
      if (bad < 40) $display("FAIL mem_addr t=%0t got=%h exp=%h", $time, bus.mem_addr, exp_addr);
    end
    if (exp_we) begin
      total++;
      if (bus.mem_wdata !== exp_data) begin
        bad++;
        if (bad < 40) $display("FAIL mem_wdata t=%0t got=%h exp=%h", $time, bus.mem_wdata, exp_data);
      end
    end
    if (bus.mem_we === 1'b1) log_q.push_back(wr_t'{addr: bus.mem_addr, data: bus.mem_wdata});

    @(posedge clk);
    #1;
    if (was_busy && npix == 0 && !flushed_m) flushed_m = 1'b1;
    if (pix_wr) pix_q.delete(0);
    if (clr_wr) begin
      idx_m++;
      if (idx_m == FBS) busy_m = 1'b0;
    end
    if (wv && exp_ready) pix_q.push_back(wr_t'{addr: wa, data: wd});
    if (cs && !was_busy) begin
      busy_m    = 1'b1;
      flushed_m = 1'b0;
      idx_m     = 0;
      color_m   = cc;
    end
  endtask

  task automatic idle_inputs();
    bus.vga_rd    = 1'b0;
    bus.vga_addr  = '0;
    bus.wr_valid  = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    bus.clr_start = 1'b0;
    bus.clr_color = '0;
    bus.mem_rdata = '0;
  endtask

  task automatic run_until_clear_done(input int limit);
    int n = 0;
    while (busy_m && n < limit) begin
      step();
      n++;
    end
    if (busy_m) begin
      bad++;
      $display("FAIL clear_timeout got=%0d cycles exp<%0d", n, limit);
    end
  endtask

  task automatic test_reset();
    @(posedge clk);
    #1;
    total++;
    if (bus.mem_we !== 1'b0) begin bad++; $display("FAIL rst_mem_we got=%b exp=0", bus.mem_we); end
    total++;
    if (bus.wr_ready !== 1'b1) begin bad++; $display("FAIL rst_wr_ready got=%b exp=1", bus.wr_ready); end
    total++;
    if (bus.clr_busy !== 1'b0) begin bad++; $display("FAIL rst_clr_busy got=%b exp=0", bus.clr_busy); end
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    step();
    step();
  endtask

  task automatic test_read_priority();
    log_q.delete();
    bus.vga_rd = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.vga_addr = AW'($urandom);
      bus.wr_valid = 1'b1;
      bus.wr_addr  = AW'(10 + i);
      bus.wr_data  = DW'(16'hA + i);
      step();
    end
    bus.wr_valid = 1'b0;
    total++;
    if (bus.wr_ready !== 1'b0) begin bad++; $display("FAIL prio_full_ready got=%b exp=0", bus.wr_ready); end
    step();
    total++;
    if (log_q.size() != 0) begin bad++; $display("FAIL prio_no_write got=%0d exp=0", log_q.size()); end
    bus.vga_rd = 1'b0;
    repeat (4) step();
    total++;
    if (log_q.size() != 4) begin
      bad++; $display("FAIL prio_drain_count got=%0d exp=4", log_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (log_q[i].addr !== AW'(10 + i) || log_q[i].data !== DW'(16'hA + i)) begin
          bad++;
          $display("FAIL prio_order[%0d] got=%h/%h exp=%h/%h", i, log_q[i].addr, log_q[i].data,
                   AW'(10 + i), DW'(16'hA + i));
        end
      end
    end
    total++;
    if (bus.wr_ready !== 1'b1) begin bad++; $display("FAIL prio_ready_back got=%b exp=1", bus.wr_ready); end
  endtask

  task automatic test_clear();
    int n = 0;
    log_q.delete();
    bus.clr_color = DW'(16'h0F0);
    bus.clr_start = 1'b1;
    step();
    bus.clr_start = 1'b0;
    bus.clr_color = DW'($urandom);
    while (busy_m && n < 100) begin
      step();
      n++;
    end
    total++;
    if (n != FBS + 1) begin bad++; $display("FAIL clear_cycles got=%0d exp=%0d", n, FBS + 1); end
    total++;
    if (bus.clr_busy !== 1'b0) begin bad++; $display("FAIL clear_busy_end got=%b exp=0", bus.clr_busy); end
    total++;
    if (log_q.size() != FBS) begin
      bad++; $display("FAIL clear_count got=%0d exp=%0d", log_q.size(), FBS);
    end else begin
      for (int i = 0; i < FBS; i++) begin
        total++;
        if (log_q[i].addr !== AW'(i) || log_q[i].data !== DW'(16'h0F0)) begin
          bad++;
          $display("FAIL clear_word[%0d] got=%h/%h exp=%h/0f0", i, log_q[i].addr, log_q[i].data, AW'(i));
        end
      end
    end
  endtask

  task automatic test_flush_then_clear();
    log_q.delete();
    bus.vga_rd = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bus.wr_valid = 1'b1;
      bus.wr_addr  = AW'(100 + i);
      bus.wr_data  = DW'(16'h700 + i);
      step();
    end
    bus.wr_valid  = 1'b0;
    bus.clr_color = DW'(16'h123);
    bus.clr_start = 1'b1;
    step();
    bus.clr_start = 1'b0;
    total++;
    if (bus.wr_ready !== 1'b0) begin bad++; $display("FAIL flush_ready got=%b exp=0", bus.wr_ready); end
    step();
    bus.vga_rd = 1'b0;
    run_until_clear_done(100);
    total++;
    if (log_q.size() != FBS + 2) begin
      bad++; $display("FAIL flush_count got=%0d exp=%0d", log_q.size(), FBS + 2);
    end else begin
      total++;
      if (log_q[0].addr !== AW'(100) || log_q[1].addr !== AW'(101) || log_q[2].addr !== AW'(0)) begin
        bad++;
        $display("FAIL flush_order got=%h,%h,%h exp=%h,%h,0", log_q[0].addr, log_q[1].addr,
                 log_q[2].addr, AW'(100), AW'(101));
      end
    end
  endtask

  task automatic test_clear_toggle_rd();
    int n = 0;
    log_q.delete();
    bus.clr_color = DW'(16'hBEEF);
    bus.clr_start = 1'b1;
    step();
    bus.clr_start = 1'b0;
    while (busy_m && n < 200) begin
      bus.vga_rd   = n[0];
      bus.vga_addr = AW'($urandom);
      step();
      n++;
    end
    bus.vga_rd = 1'b0;
    total++;
    if (busy_m) begin bad++; $display("FAIL toggle_timeout got=%0d exp<200", n); end
    total++;
    if (log_q.size() != FBS) begin
      bad++; $display("FAIL toggle_count got=%0d exp=%0d", log_q.size(), FBS);
    end else begin
      for (int i = 0; i < FBS; i++) begin
        total++;
        if (log_q[i].addr !== AW'(i)) begin
          bad++; $display("FAIL toggle_addr[%0d] got=%h exp=%h", i, log_q[i].addr, AW'(i));
        end
      end
    end
  endtask

  task automatic test_reset_mid_op();
    int n = 0;
    bus.clr_color = DW'(16'h3C3);
    bus.clr_start = 1'b1;
    step();
    bus.clr_start = 1'b0;
    while (!(flushed_m && idx_m == 5) && n < 50) begin
      step();
      n++;
    end
    total++;
    if (bus.mem_we !== 1'b1 || bus.mem_addr !== AW'(5)) begin
      bad++; $display("FAIL midclr_pre got=%b/%h exp=1/%h", bus.mem_we, bus.mem_addr, AW'(5));
    end
    #2 rstn = 1'b0;
    #1;
    model_reset();
    total++;
    if (bus.mem_we !== 1'b0) begin bad++; $display("FAIL midclr_we got=%b exp=0", bus.mem_we); end
    total++;
    if (bus.clr_busy !== 1'b0) begin bad++; $display("FAIL midclr_busy got=%b exp=0", bus.clr_busy); end
    total++;
    if (bus.wr_ready !== 1'b1) begin bad++; $display("FAIL midclr_ready got=%b exp=1", bus.wr_ready); end
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    log_q.delete();
    repeat (20) step();
    total++;
    if (log_q.size() != 0) begin bad++; $display("FAIL midclr_writes got=%0d exp=0", log_q.size()); end

    bus.vga_rd = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.wr_valid = 1'b1;
      bus.wr_addr  = AW'(200 + i);
      bus.wr_data  = DW'($urandom);
      step();
    end
    bus.wr_valid  = 1'b0;
    bus.clr_start = 1'b1;
    step();
    bus.clr_start = 1'b0;
    step();
    #2 rstn = 1'b0;
    #1;
    model_reset();
    total++;
    if (bus.clr_busy !== 1'b0 || bus.wr_ready !== 1'b1) begin
      bad++; $display("FAIL midflush_flags got=%b/%b exp=0/1", bus.clr_busy, bus.wr_ready);
    end
    @(negedge clk);
    rstn = 1'b1;
    bus.vga_rd = 1'b0;
    @(posedge clk);
    #1;
    log_q.delete();
    repeat (20) step();
    total++;
    if (log_q.size() != 0) begin bad++; $display("FAIL midflush_writes got=%0d exp=0", log_q.size()); end
  endtask

  task automatic test_clr_restart();
    int n = 0;
    log_q.delete();
    bus.clr_color = DW'(16'h555);
    bus.clr_start = 1'b1;
    step();
    bus.clr_color = DW'(16'hAAA);
    while (busy_m && n < 100) begin
      bus.clr_start = (idx_m >= 2 && idx_m <= 10);
      step();
      n++;
    end
    bus.clr_start = 1'b0;
    step();
    total++;
    if (log_q.size() != FBS) begin
      bad++; $display("FAIL restart_count got=%0d exp=%0d", log_q.size(), FBS);
    end else begin
      for (int i = 0; i < FBS; i++) begin
        total++;
        if (log_q[i].data !== DW'(16'h555)) begin
          bad++; $display("FAIL restart_color[%0d] got=%h exp=0555", i, log_q[i].data);
        end
      end
    end
  endtask

  task automatic test_random();
    int n = 0;
    for (int i = 0; i < 3000; i++) begin
      bus.vga_rd    = ($urandom_range(0, 99) < 50);
      bus.vga_addr  = AW'($urandom);
      bus.wr_valid  = ($urandom_range(0, 99) < 60);
      bus.wr_addr   = AW'($urandom);
      bus.wr_data   = DW'($urandom);
      bus.clr_start = ($urandom_range(0, 99) < 3);
      bus.clr_color = DW'($urandom);
      step();
    end
    idle_inputs();
    while ((busy_m || pix_q.size() != 0) && n < 200) begin
      step();
      n++;
    end
    total++;
    if (busy_m || pix_q.size() != 0) begin
      bad++; $display("FAIL random_drain got=%0d pending exp=0", pix_q.size());
    end
  endtask

  initial begin
    rstn = 1'b0;
    idle_inputs();
    model_reset();
    test_reset();
    test_read_priority();
    test_clear();
    test_flush_then_clear();
    test_clear_toggle_rd();
    test_reset_mid_op();
    test_clr_restart();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fb_arbiter.md
FB_ARBITER -- requirements
Module: fb_arbiter

Interface
REQ-001 Parameter ADDR_W, default 19, framebuffer word address width.
REQ-002 Parameter DATA_W, default 16, framebuffer word width.
REQ-003 Parameter FIFO_DEPTH, default 4, write-buffer entries (power of two, >=2).
REQ-004 Parameter FB_SIZE, default 307200, words swept by a clear (640x480).
REQ-005 The block SHALL have one clock, clk, and an asynchronous, active-low reset, rstn.
REQ-006 Ports:
 clk        in   1       pixel clock
 rstn       in   1       async active-low reset
 vga_rd     in   1       display read request, this cycle
 vga_addr   in   ADDR_W  display read address
 vga_data   out  DATA_W  read data to display (mem_rdata passthrough)
 wr_valid   in   1       writer has a pixel
 wr_ready   out  1       buffer accepts pixel
 wr_addr    in   ADDR_W  pixel address
 wr_data    in   DATA_W  pixel value
 clr_start  in   1       one-cycle pulse: fill framebuffer with clr_color
 clr_color  in   DATA_W  fill value, sampled on accepted clr_start
 clr_busy   out  1       clear pending or running
 mem_addr   out  ADDR_W  memory address
 mem_we     out  1       memory write enable
 mem_wdata  out  DATA_W  memory write data
 mem_rdata  in   DATA_W  memory read data

Function
REQ-007 Display reads SHALL have absolute priority: when vga_rd=1, mem_addr=vga_addr and mem_we=0 combinationally, same cycle; display latency SHALL be identical to a direct memory connection.
REQ-008 vga_data SHALL equal mem_rdata combinationally.
REQ-009 Write buffer: FIFO of FIFO_DEPTH {addr,data} entries; push on wr_valid&wr_ready at the clk edge.
REQ-010 wr_ready SHALL be 1 only when FIFO not full and state=IDLE.
REQ-011 States: IDLE, FLUSH, CLEAR.
REQ-012 IDLE: on a cycle with vga_rd=0 and FIFO non-empty, mem_we=1, mem_addr/mem_wdata=FIFO head; head popped at that edge.
REQ-013 Simultaneous push and pop on a full FIFO SHALL NOT occur (wr_ready=0 when full); push and pop on a non-full, non-empty FIFO SHALL both take effect, count unchanged.
REQ-014 clr_start in IDLE SHALL latch clr_color, set clr_busy next cycle, and enter FLUSH; clr_start in FLUSH or CLEAR SHALL be ignored.
REQ-015 FLUSH: drain FIFO per REQ-012; when FIFO empty, go to CLEAR with clear counter=0 (FIFO already empty at clr_start: FLUSH lasts one cycle).
REQ-016 CLEAR: on each cycle with vga_rd=0, mem_we=1, mem_addr=counter, mem_wdata=latched color, counter+1; counter holds while vga_rd=1.
REQ-017 The write at counter=FB_SIZE-1 SHALL be the last; next state IDLE, clr_busy=0 on the following cycle; counter SHALL never exceed FB_SIZE-1.
REQ-018 Counter width SHALL be ADDR_W; no wrap past FB_SIZE.
REQ-019 Whenever no write is issued and vga_rd=0, mem_we=0 and mem_addr=vga_addr.
REQ-020 The block SHALL never assert mem_we in a cycle with vga_rd=1.

Reset
REQ-021 rstn=0 SHALL asynchronously force: state IDLE, FIFO empty, counter 0, latched color 0, clr_busy=0; wr_ready=1 and mem_we=0 (vga_rd=0) while in reset and after release.
REQ-022 Reset mid-clear or mid-flush SHALL discard buffered pixels and the clear; no further writes issue.

Verification
REQ-023 vga_rd=1 continuously, 4 pushes (addr 10..13, data 0xA..0xD) -> wr_ready=0 after 4th, mem_we stays 0; drop vga_rd -> 4 writes in order on 4 consecutive cycles, wr_ready=1 again.
REQ-024 FB_SIZE=16, clr_color=0x0F0, vga_rd=0 -> 1 FLUSH cycle, 16 writes addr 0..15 of 0x0F0, clr_busy low the cycle after addr 15.
REQ-025 2 pixels buffered with vga_rd=1, then clr_start -> wr_ready=0; on vga_rd=0 both pixels written before addr 0 of clear.
REQ-026 Clear with vga_rd toggling 1/0 each cycle -> writes only on vga_rd=0 cycles, addresses strictly consecutive, mem_addr=vga_addr on read cycles.
REQ-027 rstn pulsed low at clear counter=5 -> mem_we=0 immediately, clr_busy=0, FIFO empty, wr_ready=1 after release.
REQ-028 clr_start repeated during CLEAR -> ignored, exactly FB_SIZE clear writes total.
